// File: rtl/ddr3_line_buffer_pkg.sv
// ddr3_linebuf_pkg: geometry constants, FSM state encoding and byte-merge
// helper shared by the single-line DDR3 buffer.
// Optional feature: DDR3_LINEBUF_FLUSH_EN adds the flush states.
package ddr3_linebuf_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned MEM_AW   = 29;
    localparam int unsigned TAG_W    = 24;
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_WB,
        ST_FILL
`ifdef DDR3_LINEBUF_FLUSH_EN
        ,
        ST_FLUSH_WB,
        ST_FLUSH_RESP
`endif
    } state_e;

    // Replace the bytes of old_w whose enable bit is set with those of new_w.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr3_line_buffer_if.sv
// ddr3_line_buffer_if: CPU word bus and memory line bus of the line buffer.
// slave = the line buffer, master = CPU plus memory controller side.
// Optional feature: DDR3_LINEBUF_FLUSH_EN adds flush_i / flush_ack_o.
interface ddr3_line_buffer_if;
    import ddr3_linebuf_pkg::*;

    logic [31:0]       addr_i;
    logic [31:0]       data_i;
    logic [3:0]        sel_i;
    logic              rd_i;
    logic              we_i;
    logic [31:0]       data_o;
    logic              ack_o;

    logic [MEM_AW-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_we_o;
    logic              mem_rd_o;
    logic              mem_ack_i;

`ifdef DDR3_LINEBUF_FLUSH_EN
    logic              flush_i;
    logic              flush_ack_o;
`endif

    modport slave (
        input  addr_i, data_i, sel_i, rd_i, we_i, mem_data_i, mem_ack_i,
`ifdef DDR3_LINEBUF_FLUSH_EN
        input  flush_i,
        output flush_ack_o,
`endif
        output data_o, ack_o, mem_addr_o, mem_data_o, mem_we_o, mem_rd_o
    );

    modport master (
        output addr_i, data_i, sel_i, rd_i, we_i, mem_data_i, mem_ack_i,
`ifdef DDR3_LINEBUF_FLUSH_EN
        output flush_i,
        input  flush_ack_o,
`endif
        input  data_o, ack_o, mem_addr_o, mem_data_o, mem_we_o, mem_rd_o
    );

endinterface

// File: rtl/ddr3_line_buffer.sv
// ddr3_line_buffer: single 256-bit write-back line in front of DDR3.
// Hits complete in one cycle; misses write back a dirty line, then fill.
// Optional feature: DDR3_LINEBUF_FLUSH_EN adds a flush request that writes
// back a dirty line and acknowledges with flush_ack_o.
module ddr3_line_buffer
    import ddr3_linebuf_pkg::*;
(
    input logic               clk,
    input logic               rst,
    ddr3_line_buffer_if.slave bus
);

    state_e            r_state;
    logic [LINE_W-1:0] r_line;
    logic [TAG_W-1:0]  r_tag;
    logic              r_valid;
    logic              r_dirty;
    logic [31:0]       r_data;
    logic              r_ack;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_data;
    logic              r_mem_we;
    logic              r_mem_rd;
`ifdef DDR3_LINEBUF_FLUSH_EN
    logic              r_flush_ack;
`endif

    logic [TAG_W-1:0]  w_tag;
    logic [2:0]        w_word;
    logic [7:0]        w_bit_ofs;
    logic              w_hit;
    logic              w_req;
    logic              w_write;
    logic [31:0]       w_cur_word;
    logic [31:0]       w_merged;
    logic              w_unused;

    assign w_tag      = bus.addr_i[MEM_AW-1:OFFSET_W];
    assign w_word     = bus.addr_i[OFFSET_W-1:2];
    assign w_bit_ofs  = {w_word, 5'b0};
    assign w_hit      = r_valid && (r_tag == w_tag);
    assign w_req      = bus.rd_i || bus.we_i;
    assign w_write    = bus.we_i;
    assign w_cur_word = r_line[w_bit_ofs +: 32];
    assign w_merged   = byte_merge(w_cur_word, bus.data_i, bus.sel_i);
    assign w_unused   = ^{bus.addr_i[31:MEM_AW], bus.addr_i[1:0]};

    // Single FSM: state, line storage and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_line     <= '0;
            r_tag      <= '0;
            r_valid    <= 1'b0;
            r_dirty    <= 1'b0;
            r_data     <= '0;
            r_ack      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_mem_rd   <= 1'b0;
`ifdef DDR3_LINEBUF_FLUSH_EN
            r_flush_ack <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                            if (w_write) begin
                                r_line[w_bit_ofs +: 32] <= w_merged;
                                r_dirty                 <= 1'b1;
                            end else begin
                                r_data <= w_cur_word;
                            end
                        end else if (r_valid && r_dirty) begin
                            r_state    <= ST_WB;
                            r_mem_addr <= {r_tag, {OFFSET_W{1'b0}}};
                            r_mem_data <= r_line;
                            r_mem_we   <= 1'b1;
                        end else begin
                            r_state    <= ST_FILL;
                            r_mem_addr <= {w_tag, {OFFSET_W{1'b0}}};
                            r_mem_rd   <= 1'b1;
                        end
                    end
`ifdef DDR3_LINEBUF_FLUSH_EN
                    else if (bus.flush_i) begin
                        if (r_dirty) begin
                            r_state    <= ST_FLUSH_WB;
                            r_mem_addr <= {r_tag, {OFFSET_W{1'b0}}};
                            r_mem_data <= r_line;
                            r_mem_we   <= 1'b1;
                        end else begin
                            r_state     <= ST_FLUSH_RESP;
                            r_flush_ack <= 1'b1;
                        end
                    end
`endif
                end
                ST_RESP: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_WB: begin
                    if (bus.mem_ack_i) begin
                        r_dirty    <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_tag, {OFFSET_W{1'b0}}};
                        r_mem_rd   <= 1'b1;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.mem_ack_i) begin
                        r_line   <= bus.mem_data_i;
                        r_tag    <= r_mem_addr[MEM_AW-1:OFFSET_W];
                        r_valid  <= 1'b1;
                        r_dirty  <= 1'b0;
                        r_mem_rd <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
`ifdef DDR3_LINEBUF_FLUSH_EN
                ST_FLUSH_WB: begin
                    if (bus.mem_ack_i) begin
                        r_dirty     <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_flush_ack <= 1'b1;
                        r_state     <= ST_FLUSH_RESP;
                    end
                end
                ST_FLUSH_RESP: begin
                    r_flush_ack <= 1'b0;
                    r_state     <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_o     = r_data;
    assign bus.ack_o      = r_ack;
    assign bus.mem_addr_o = r_mem_addr;
    assign bus.mem_data_o = r_mem_data;
    assign bus.mem_we_o   = r_mem_we;
    assign bus.mem_rd_o   = r_mem_rd;
`ifdef DDR3_LINEBUF_FLUSH_EN
    assign bus.flush_ack_o = r_flush_ack;
`endif

endmodule

// File: tb/tb_ddr3_line_buffer.sv
// tb_ddr3_line_buffer: directed bench for ddr3_line_buffer.
// Hit behaviour is table driven; miss, write-back, reset and flush
// (DDR3_LINEBUF_FLUSH_EN) sequences are hand written.
module tb_ddr3_line_buffer;
    import ddr3_linebuf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr3_line_buffer_if bus();

    ddr3_line_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_ack     = 0;
    int   n_we_rise = 0;
    int   n_rd_rise = 0;
    logic prev_we   = 1'b0;
    logic prev_rd   = 1'b0;

    // Count ack cycles and rising edges of the memory requests.
    always @(posedge clk) begin
        if (bus.ack_o === 1'b1) n_ack <= n_ack + 1;
        prev_we <= bus.mem_we_o;
        prev_rd <= bus.mem_rd_o;
        if (bus.mem_we_o === 1'b1 && prev_we !== 1'b1) n_we_rise <= n_we_rise + 1;
        if (bus.mem_rd_o === 1'b1 && prev_rd !== 1'b1) n_rd_rise <= n_rd_rise + 1;
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        chk_rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    logic [255:0] L0, L0M, L1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_drive(input logic rd, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        bus.rd_i   = rd;
        bus.we_i   = we;
        bus.addr_i = a;
        bus.data_i = d;
        bus.sel_i  = s;
    endtask

    task automatic cpu_release();
        @(posedge clk);
        #1;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wait_ack(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (bus.ack_o === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic mem_ack_pulse(input logic [255:0] d);
        @(posedge clk);
        #1;
        bus.mem_data_i = d;
        bus.mem_ack_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ack_i  = 1'b0;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ack"},      256'(bus.ack_o),      256'd0);
        check({pfx, "_data"},     256'(bus.data_o),     256'd0);
        check({pfx, "_mem_we"},   256'(bus.mem_we_o),   256'd0);
        check({pfx, "_mem_rd"},   256'(bus.mem_rd_o),   256'd0);
        check({pfx, "_mem_addr"}, 256'(bus.mem_addr_o), 256'd0);
        check({pfx, "_mem_data"}, bus.mem_data_o,       256'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int a0;
        int w0;

        L0  = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
               32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h00001111};
        L0M = {32'hAABB7777, 32'h66666666, 32'h55555555, 32'h44EE4444,
               32'h33333333, 32'h55667788, 32'hDEAD3344, 32'h00001111};
        L1  = {32'h70707070, 32'h60606060, 32'h50505050, 32'h40404040,
               32'h30303030, 32'h20202020, 32'hCAFEF00D, 32'h00000200};

        vecs[0]  = '{"wr_w1_lo",  1'b0, 1'b1, 32'h0000_0104, 32'h11223344, 4'b0011, 1'b0, 32'h0};
        vecs[1]  = '{"rd_w1",     1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'b0000, 1'b1, 32'hDEAD3344};
        vecs[2]  = '{"rd_w0",     1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 1'b1, 32'h00001111};
        vecs[3]  = '{"wr_w7_hi",  1'b0, 1'b1, 32'h0000_011C, 32'hAABBCCDD, 4'b1100, 1'b0, 32'h0};
        vecs[4]  = '{"rd_w7",     1'b1, 1'b0, 32'h0000_011C, 32'h0,        4'b0000, 1'b1, 32'hAABB7777};
        vecs[5]  = '{"rdwe_w2",   1'b1, 1'b1, 32'h0000_0108, 32'h55667788, 4'b1111, 1'b0, 32'h0};
        vecs[6]  = '{"rd_w2",     1'b1, 1'b0, 32'h0000_0108, 32'h0,        4'b0000, 1'b1, 32'h55667788};
        vecs[7]  = '{"wr_w3_none",1'b0, 1'b1, 32'h0000_010C, 32'h99999999, 4'b0000, 1'b0, 32'h0};
        vecs[8]  = '{"rd_w3",     1'b1, 1'b0, 32'h0000_010C, 32'h0,        4'b0000, 1'b1, 32'h33333333};
        vecs[9]  = '{"wr_w4_b2",  1'b0, 1'b1, 32'h0000_0110, 32'h00EE0000, 4'b0100, 1'b0, 32'h0};
        vecs[10] = '{"rd_w4",     1'b1, 1'b0, 32'h0000_0110, 32'h0,        4'b0000, 1'b1, 32'h44EE4444};
        vecs[11] = '{"rd_hi_bits",1'b1, 1'b0, 32'hE000_0107, 32'h0,        4'b0000, 1'b1, 32'hDEAD3344};

        rst = 1'b1;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.mem_data_i = '0;
        bus.mem_ack_i  = 1'b0;
`ifdef DDR3_LINEBUF_FLUSH_EN
        bus.flush_i    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold read miss, fill, then hit.
        a0 = n_ack;
        cpu_drive(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
        step();
        check("cold_mem_rd",   256'(bus.mem_rd_o),   256'd1);
        check("cold_mem_we",   256'(bus.mem_we_o),   256'd0);
        check("cold_mem_addr", 256'(bus.mem_addr_o), 256'h100);
        step();
        check("cold_rd_hold",  256'(bus.mem_rd_o),   256'd1);
        check("cold_no_ack",   256'(bus.ack_o),      256'd0);
        mem_ack_pulse(L0);
        wait_ack(4, lat);
        check("cold_lat",      256'(lat),            256'd1);
        check("cold_data",     256'(bus.data_o),     256'hDEADBEEF);
        check("cold_rd_drop",  256'(bus.mem_rd_o),   256'd0);
        cpu_release();
        repeat (3) step();
        check("cold_one_ack",  256'(n_ack - a0),     256'd1);

        // Hit table: one-cycle latency, one ack, no memory traffic.
        for (int i = 0; i < NV; i++) begin
            a0 = n_ack;
            cpu_drive(vecs[i].rd, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel);
            wait_ack(4, lat);
            check({vecs[i].name, "_lat"}, 256'(lat), 256'd1);
            if (vecs[i].chk_rd) check({vecs[i].name, "_data"}, 256'(bus.data_o), 256'(vecs[i].exp));
            cpu_release();
            step();
            check({vecs[i].name, "_ackcnt"}, 256'(n_ack - a0), 256'd1);
        end

        // mem_ack_i while idle must be ignored.
        mem_ack_pulse('1);
        step();
        check("stray_ack_we", 256'(bus.mem_we_o), 256'd0);
        check("stray_ack_rd", 256'(bus.mem_rd_o), 256'd0);
        cpu_drive(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
        wait_ack(4, lat);
        check("stray_ack_lat",  256'(lat),        256'd1);
        check("stray_ack_data", 256'(bus.data_o), 256'hDEAD3344);
        cpu_release();
        step();
        check("hits_rd_rises", 256'(n_rd_rise), 256'd1);
        check("hits_we_rises", 256'(n_we_rise), 256'd0);

        // Dirty miss: write back old line, then fill the new one.
        cpu_drive(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0);
        step();
        check("wb_we",       256'(bus.mem_we_o),   256'd1);
        check("wb_rd_low",   256'(bus.mem_rd_o),   256'd0);
        check("wb_addr",     256'(bus.mem_addr_o), 256'h100);
        check("wb_data",     bus.mem_data_o,       L0M);
        step();
        check("wb_we_hold",  256'(bus.mem_we_o),   256'd1);
        check("wb_rd_idle",  256'(bus.mem_rd_o),   256'd0);
        mem_ack_pulse('0);
        @(negedge clk);
        check("wb2fill_rd",  256'(bus.mem_rd_o),   256'd1);
        check("wb2fill_we",  256'(bus.mem_we_o),   256'd0);
        check("wb2fill_addr",256'(bus.mem_addr_o), 256'h200);
        mem_ack_pulse(L1);
        wait_ack(4, lat);
        check("wbfill_lat",  256'(lat),            256'd1);
        check("wbfill_data", 256'(bus.data_o),     256'hCAFEF00D);
        cpu_release();
        step();
        check("wb_rd_rises", 256'(n_rd_rise), 256'd2);
        check("wb_we_rises", 256'(n_we_rise), 256'd1);

`ifdef DDR3_LINEBUF_FLUSH_EN
        // Dirty the line, flush it, then flush a clean line.
        cpu_drive(1'b0, 1'b1, 32'h0000_0200, 32'h12345678, 4'b1111);
        wait_ack(4, lat);
        check("fl_wr_lat", 256'(lat), 256'd1);
        cpu_release();
        w0 = n_we_rise;
        bus.flush_i = 1'b1;
        step();
        check("fl_we",        256'(bus.mem_we_o),    256'd1);
        check("fl_addr",      256'(bus.mem_addr_o),  256'h200);
        check("fl_early_ack", 256'(bus.flush_ack_o), 256'd0);
        mem_ack_pulse('0);
        @(negedge clk);
        check("fl_ack",       256'(bus.flush_ack_o), 256'd1);
        check("fl_we_drop",   256'(bus.mem_we_o),    256'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        step();
        check("fl_ack_pulse", 256'(bus.flush_ack_o), 256'd0);
        bus.flush_i = 1'b1;
        step();
        check("fl2_ack",      256'(bus.flush_ack_o), 256'd1);
        check("fl2_no_we",    256'(bus.mem_we_o),    256'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        step();
        check("fl_we_rises",  256'(n_we_rise - w0),  256'd1);
`else
        w0 = n_we_rise;
`endif

        // Reset in the middle of a fill.
        cpu_drive(1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0);
        step();
        check("rstfill_rd", 256'(bus.mem_rd_o), 256'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        a0 = n_ack;
        step();
        check_zero("rstfill");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step();
        check("rstfill_no_ack", 256'(n_ack - a0), 256'd0);

        // The previously resident line must now miss.
        cpu_drive(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0);
        step();
        check("post_rst_miss_rd",   256'(bus.mem_rd_o),   256'd1);
        check("post_rst_miss_we",   256'(bus.mem_we_o),   256'd0);
        check("post_rst_miss_addr", 256'(bus.mem_addr_o), 256'h200);
        mem_ack_pulse(L1);
        wait_ack(4, lat);
        check("post_rst_lat",  256'(lat),        256'd1);
        check("post_rst_data", 256'(bus.data_o), 256'hCAFEF00D);
        cpu_release();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_line_buffer.md
DDR3_LINE_BUFFER -- requirements
Module: ddr3_line_buffer

Interface
REQ-001 SHALL have input clk, 1 bit, system clock; the memory side runs in the same domain.
REQ-002 SHALL have input rst, 1 bit, reset: synchronous, active-high.
REQ-003 SHALL have input addr_i, 32 bits, CPU byte address; only bits [28:2] are used.
REQ-004 SHALL have input data_i, 32 bits, CPU write word.
REQ-005 SHALL have input sel_i, 4 bits, byte enables for writes.
REQ-006 SHALL have input rd_i, 1 bit, read request, level-held until ack_o.
REQ-007 SHALL have input we_i, 1 bit, write request, level-held until ack_o.
REQ-008 SHALL have output data_o, 32 bits, read word, valid while ack_o=1.
REQ-009 SHALL have output ack_o, 1 bit, single-cycle completion pulse.
REQ-010 SHALL have output mem_addr_o, 29 bits, line byte address with bits [4:0]=0.
REQ-011 SHALL have output mem_data_o, 256 bits, write-back line.
REQ-012 SHALL have input mem_data_i, 256 bits, fill line, stable when mem_ack_i=1.
REQ-013 SHALL have output mem_we_o, 1 bit, line write request.
REQ-014 SHALL have output mem_rd_o, 1 bit, line read request.
REQ-015 SHALL have input mem_ack_i, 1 bit, single-cycle memory completion pulse.

Function
REQ-016 SHALL hold one 256-bit line with a 24-bit tag (addr[28:5]), a valid bit and a dirty bit.
- Word w = addr[4:2] occupies line bits [32w+31:32w].
REQ-017 SHALL define a hit as valid && tag==addr_i[28:5]; rd_i and we_i both high SHALL be treated as a write.
REQ-018 SHALL implement the states IDLE, RESP, WB, FILL (plus FLUSH_WB and FLUSH_RESP, see Configuration).
REQ-019 SHALL, in IDLE on a request hit, go to RESP:
- For a read, register the selected word into data_o.
- For a write, merge the bytes enabled by sel_i and set dirty.
REQ-020 SHALL drive ack_o=1 only in RESP; RESP SHALL return to IDLE unconditionally and ignore rd_i/we_i in that cycle, so that hit latency is 1 cycle.
REQ-021 SHALL, in IDLE on a miss:
- Go to WB when the line is valid and dirty: mem_addr_o={old tag,5'b0}, mem_data_o=line, mem_we_o=1.
- Otherwise go to FILL: mem_addr_o={addr_i[28:5],5'b0}, mem_rd_o=1.
REQ-022 SHALL, in WB on mem_ack_i: clear dirty, drop mem_we_o, and enter FILL with mem_rd_o=1 and the new address in the same cycle.
REQ-023 SHALL, in FILL on mem_ack_i: load mem_data_i, set the tag, valid=1, dirty=0, drop mem_rd_o, and go to IDLE; the request is then served as a hit.
REQ-024 SHALL register mem_we_o and mem_rd_o, never assert them together, and hold each high from issue until mem_ack_i.
REQ-025 SHALL keep each memory request low for at least 1 cycle between successive assertions, because downstream detects rising edges.
REQ-026 SHALL ignore mem_ack_i outside WB and FILL.

Reset
REQ-027 SHALL, on rst, set: state=IDLE; valid=0; dirty=0; tag=0; line=0; data_o=0; ack_o=0; mem_we_o=0; mem_rd_o=0; mem_addr_o=0; mem_data_o=0.
REQ-028 SHALL, on rst mid-WB or mid-FILL, abandon the transfer and discard dirty data; no ack_o SHALL follow.

Configuration
REQ-029 SHALL, with DDR3_LINEBUF_FLUSH_EN defined, add input flush_i (level-held) and output flush_ack_o (1-cycle pulse).
- In IDLE with no CPU request (CPU requests have priority): if dirty, go to FLUSH_WB (write back, keep valid, clear dirty) and then FLUSH_RESP; otherwise go directly to FLUSH_RESP.
- flush_ack_o=1 only in FLUSH_RESP; FLUSH_RESP returns to IDLE and ignores flush_i in that cycle.
REQ-030 SHALL, without DDR3_LINEBUF_FLUSH_EN, have neither the flush ports nor the FLUSH states.

Structure
REQ-031 SHALL place LINE_W=256, MEM_AW=29, TAG_W=24, OFFSET_W=5, the state enum and a byte-merge function in package ddr3_linebuf_pkg.
REQ-032 SHALL have no sub-module; a single FSM plus datapath registers.

Verification
REQ-033 Cold read 0x0000_0104, then mem_ack_i with line word1=0xDEAD_BEEF -> mem_rd_o with mem_addr_o=0x0000100; then data_o=0xDEAD_BEEF with one ack_o pulse.
REQ-034 Write 0x1122_3344, sel_i=4'b0011, to 0x104 after REQ-033 -> ack_o one cycle after the request; a subsequent read returns 0xDEAD_3344; no memory traffic.
REQ-035 Read 0x0000_0204 with a dirty line -> mem_we_o to 0x0000100 with the merged line; one idle cycle of mem_rd_o before it rises with addr 0x0000200.
REQ-036 Request held through the ack_o cycle -> exactly one ack_o pulse per request.
REQ-037 rst asserted during FILL -> all outputs zero next cycle; the next read misses.
REQ-038 (FLUSH_EN) flush_i with a dirty line -> one mem_we_o, then a flush_ack_o pulse; a following flush gives flush_ack_o with no mem_we_o.
